// File: rtl/glyph_pixel_renderer_pkg.sv
// Shared constants for the glyph pixel renderer: colours, glyph geometry, pipeline depth.
// INVERSE_VIDEO_EN selects a 128-glyph font (10-bit ROM address) with bit 7 as inverse flag.
package glyph_pixel_renderer_pkg;

  typedef logic [2:0] color_t;

  localparam color_t BLACK   = 3'b000;
  localparam color_t BLUE    = 3'b001;
  localparam color_t GREEN   = 3'b010;
  localparam color_t CYAN    = 3'b011;
  localparam color_t RED     = 3'b100;
  localparam color_t MAGENTA = 3'b101;
  localparam color_t YELLOW  = 3'b110;
  localparam color_t WHITE   = 3'b111;

  localparam int GLYPH_W  = 8;
  localparam int GLYPH_H  = 8;
  localparam int PIPE_LAT = 4;

`ifdef INVERSE_VIDEO_EN
  localparam int ROM_AW = 10;
`else
  localparam int ROM_AW = 11;
`endif

endpackage

// File: rtl/glyph_pixel_renderer_if.sv
// Pixel-stream bundle between the beam/text components and the glyph renderer.
// master drives beam position, syncs and component outputs; slave returns RGB and delayed syncs.
interface glyph_pixel_renderer_if;
  logic [9:0] x;
  logic [9:0] y;
  logic       active_in;
  logic       hsync_in;
  logic       vsync_in;
  logic [7:0] char_in;
  logic [2:0] color_in;
  logic [1:0] zoom_in;
  logic       h2a_in;
  logic [2:0] rgb;
  logic       hsync;
  logic       vsync;

  modport master (
    output x, y, active_in, hsync_in, vsync_in, char_in, color_in, zoom_in, h2a_in,
    input  rgb, hsync, vsync
  );

  modport slave (
    input  x, y, active_in, hsync_in, vsync_in, char_in, color_in, zoom_in, h2a_in,
    output rgb, hsync, vsync
  );
endinterface

// File: rtl/glyph_pixel_renderer_font_rom.sv
// Synchronous-read 8x8 font ROM, one glyph row per address {code,row}, 1-cycle latency.
// Built-in image: digits and A-F drawn, code 0 and space blank, any other code draws a box.
module glyph_pixel_renderer_font_rom
  import glyph_pixel_renderer_pkg::*;
#(
  parameter int ADDR_W = ROM_AW
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  output logic [7:0]        data
);

  function automatic logic [63:0] bitmap(input logic [7:0] code);
    case (code)
      8'h00, 8'h20: bitmap = 64'h0000000000000000;
      8'h30: bitmap = 64'h3C666E7666663C00;
      8'h31: bitmap = 64'h1838181818187E00;
      8'h32: bitmap = 64'h3C66060C18307E00;
      8'h33: bitmap = 64'h3C66061C06663C00;
      8'h34: bitmap = 64'h0C1C3C6C7E0C0C00;
      8'h35: bitmap = 64'h7E607C0606663C00;
      8'h36: bitmap = 64'h3C60607C66663C00;
      8'h37: bitmap = 64'h7E060C1830303000;
      8'h38: bitmap = 64'h3C66663C66663C00;
      8'h39: bitmap = 64'h3C66663E06063C00;
      8'h41: bitmap = 64'h183C66667E666600;
      8'h42: bitmap = 64'h7C66667C66667C00;
      8'h43: bitmap = 64'h3C66606060663C00;
      8'h44: bitmap = 64'h786C6666666C7800;
      8'h45: bitmap = 64'h7E60607C60607E00;
      8'h46: bitmap = 64'h7E60607C60606000;
      default: bitmap = 64'hFF818181818181FF;
    endcase
  endfunction

  function automatic logic [7:0] glyph_row(input logic [ADDR_W-1:0] a);
    logic [63:0] sh;
    sh = bitmap(8'(a[ADDR_W-1:3])) << {a[2:0], 3'b000};
    glyph_row = sh[63:56];
  endfunction

  always_ff @(posedge clk) begin
    data <= glyph_row(addr);
  end

endmodule

// File: rtl/glyph_pixel_renderer.sv
// Four-stage text pixel renderer: aligns beam with component outputs, reads the font ROM and
// emits RGB plus equally delayed syncs. Define INVERSE_VIDEO_EN for per-char inverse video.
module glyph_pixel_renderer
  import glyph_pixel_renderer_pkg::*;
#(
  parameter color_t BG_COLOR  = BLACK,
  parameter logic   SYNC_IDLE = 1'b1
) (
  input  logic px_clk,
  input  logic reset,
  glyph_pixel_renderer_if.slave pix
);

  function automatic logic [7:0] hex2ascii(input logic [3:0] n);
    hex2ascii = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  logic [9:0] x0, y0;
  logic       act0, hs0, vs0;

  logic [7:0] code1;
  logic [2:0] row1, col1;
  color_t     color1;
  logic       act1, hs1, vs1;

  logic [7:0] glyph2;
  logic [2:0] col2;
  color_t     color2;
  logic       act2, hs2, vs2;

  color_t     rgb_q;
  logic       hsync_q, vsync_q;

  logic [7:0] code_s1;
  logic [9:0] xs, ys;
  logic [ROM_AW-1:0] rom_addr;
  logic       glyph_bit, lit;
  logic       unused_bits;

  always_comb begin
    code_s1 = pix.h2a_in ? hex2ascii(pix.char_in[3:0]) : pix.char_in;
    xs      = x0 >> pix.zoom_in;
    ys      = y0 >> pix.zoom_in;
  end

  assign unused_bits = ^{xs[9:3], ys[9:3]};

  // Sync stages reset to SYNC_IDLE so the pins stay idle while the pipeline refills.
  always_ff @(posedge px_clk or posedge reset) begin
    if (reset) begin
      x0     <= '0;
      y0     <= '0;
      act0   <= 1'b0;
      hs0    <= SYNC_IDLE;
      vs0    <= SYNC_IDLE;
      code1  <= '0;
      row1   <= '0;
      col1   <= '0;
      color1 <= '0;
      act1   <= 1'b0;
      hs1    <= SYNC_IDLE;
      vs1    <= SYNC_IDLE;
      col2   <= '0;
      color2 <= '0;
      act2   <= 1'b0;
      hs2    <= SYNC_IDLE;
      vs2    <= SYNC_IDLE;
    end else begin
      x0     <= pix.x;
      y0     <= pix.y;
      act0   <= pix.active_in;
      hs0    <= pix.hsync_in;
      vs0    <= pix.vsync_in;
      code1  <= code_s1;
      row1   <= ys[2:0];
      col1   <= xs[2:0];
      color1 <= pix.color_in;
      act1   <= act0;
      hs1    <= hs0;
      vs1    <= vs0;
      col2   <= col1;
      color2 <= color1;
      act2   <= act1;
      hs2    <= hs1;
      vs2    <= vs1;
    end
  end

`ifdef INVERSE_VIDEO_EN
  logic inv2;

  always_ff @(posedge px_clk or posedge reset) begin
    if (reset) inv2 <= 1'b0;
    else       inv2 <= code1[7];
  end

  assign rom_addr = {code1[6:0], row1};
  assign lit      = glyph_bit ^ inv2;
`else
  assign rom_addr = {code1, row1};
  assign lit      = glyph_bit;
`endif

  glyph_pixel_renderer_font_rom #(.ADDR_W(ROM_AW)) u_font_rom (
    .clk  (px_clk),
    .addr (rom_addr),
    .data (glyph2)
  );

  assign glyph_bit = glyph2[3'd7 - col2];

  always_ff @(posedge px_clk or posedge reset) begin
    if (reset) begin
      rgb_q   <= BG_COLOR;
      hsync_q <= SYNC_IDLE;
      vsync_q <= SYNC_IDLE;
    end else begin
      rgb_q   <= (act2 && lit) ? color2 : BG_COLOR;
      hsync_q <= hs2;
      vsync_q <= vs2;
    end
  end

  assign pix.rgb   = rgb_q;
  assign pix.hsync = hsync_q;
  assign pix.vsync = vsync_q;

endmodule
